// File: rtl/cpu_run_controller_if.sv
// RAM read / dump handshake bundle between cpu_run_controller (master)
// and the top-level RAM address mux plus dump consumer (slave).
interface cpu_run_controller_if #(
    parameter int NB_INSTRUCTION = 16,
    parameter int NB_ADDR        = 11
);
    logic                      o_dump_active;
    logic [NB_ADDR-1:0]        o_ram_addr;
    logic                      o_ram_rd_enable;
    logic [NB_INSTRUCTION-1:0] i_ram_data;
    logic [NB_INSTRUCTION-1:0] o_dump_data;
    logic                      o_dump_valid;
    logic                      i_dump_ready;

    modport master (
        output o_dump_active, o_ram_addr, o_ram_rd_enable, o_dump_data, o_dump_valid,
        input  i_ram_data, i_dump_ready
    );

    modport slave (
        input  o_dump_active, o_ram_addr, o_ram_rd_enable, o_dump_data, o_dump_valid,
        output i_ram_data, i_dump_ready
    );
endinterface

// File: rtl/cpu_run_controller.sv
// Run/step controller for the CPU with a post-halt RAM dump over a valid/ready port.
// Optional RUN-mode watchdog is enabled by defining RUN_CTRL_WATCHDOG_EN.
//
// state      | meaning
// IDLE       | waiting for i_start
// CLEAR      | one-cycle CPU clear pulse
// RUN        | free run until HALT (or watchdog)
// STEP_WAIT  | CPU paused, waiting for i_step or HALT
// STEP_EXEC  | one enabled CPU cycle
// DUMP_ADDR  | present dump address with read strobe
// DUMP_DATA  | hold dump word until consumer is ready
// DONE       | dump finished, results held
module cpu_run_controller #(
    parameter int NB_INSTRUCTION = 16,
    parameter int NB_ADDR        = 11,
    parameter int NB_OPCODE      = 5,
    parameter int HALT_OPCODE    = 0,
    parameter int DUMP_DEPTH     = 16,
    parameter int NB_CYCLES      = 16,
    parameter int WATCHDOG_LIMIT = 1000
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic                 i_step_mode,
    input  logic                 i_step,
    input  logic [NB_OPCODE-1:0] i_opcode,
    output logic                 o_cpu_enable,
    output logic                 o_cpu_clear,
    output logic [NB_CYCLES-1:0] o_cycle_count,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_timeout,
    cpu_run_controller_if.master io_dump
);
    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_RUN, S_STEP_WAIT, S_STEP_EXEC, S_DUMP_ADDR, S_DUMP_DATA, S_DONE
    } state_t;

    localparam logic [NB_OPCODE-1:0] HALT      = NB_OPCODE'(HALT_OPCODE);
    localparam logic [NB_ADDR-1:0]   LAST_ADDR = NB_ADDR'(DUMP_DEPTH - 1);

    state_t                    r_state;
    state_t                    w_next;
    logic                      r_step_mode;
    logic [NB_CYCLES-1:0]      r_cycle_count;
    logic [NB_ADDR-1:0]        r_dump_addr;
    logic [NB_INSTRUCTION-1:0] r_dump_data;

    logic w_cpu_enable;
    logic w_cpu_clear;
    logic w_dump_active;
    logic w_rd_enable;
    logic w_dump_valid;
    logic w_start_accept;
    logic w_dump_enter;
    logic w_handshake;
    logic w_is_halt;
    logic w_last;
`ifdef RUN_CTRL_WATCHDOG_EN
    localparam logic [NB_CYCLES-1:0] WD_LIMIT = NB_CYCLES'(WATCHDOG_LIMIT);
    logic w_wd_fire;
    logic r_timeout;
`endif

    assign w_is_halt   = (i_opcode == HALT);
    assign w_last      = (r_dump_addr == LAST_ADDR);
    assign w_handshake = w_dump_valid & io_dump.i_dump_ready;

    always_comb begin
        w_next         = r_state;
        w_cpu_enable   = 1'b0;
        w_cpu_clear    = 1'b0;
        w_dump_active  = 1'b0;
        w_rd_enable    = 1'b0;
        w_dump_valid   = 1'b0;
        w_start_accept = 1'b0;
        w_dump_enter   = 1'b0;
`ifdef RUN_CTRL_WATCHDOG_EN
        w_wd_fire      = 1'b0;
`endif
        case (r_state)
            S_IDLE, S_DONE: begin
                if (i_start) begin
                    w_next         = S_CLEAR;
                    w_start_accept = 1'b1;
                end
            end
            S_CLEAR: begin
                w_cpu_clear = 1'b1;
                w_next      = r_step_mode ? S_STEP_WAIT : S_RUN;
            end
            S_RUN: begin
`ifdef RUN_CTRL_WATCHDOG_EN
                if (r_cycle_count == WD_LIMIT) begin
                    w_wd_fire    = 1'b1;
                    w_dump_enter = 1'b1;
                    w_next       = S_DUMP_ADDR;
                end else
`endif
                if (w_is_halt) begin
                    w_dump_enter = 1'b1;
                    w_next       = S_DUMP_ADDR;
                end else begin
                    w_cpu_enable = 1'b1;
                end
            end
            S_STEP_WAIT: begin
                // HALT outranks a coincident step so the halted instruction never executes
                if (w_is_halt) begin
                    w_dump_enter = 1'b1;
                    w_next       = S_DUMP_ADDR;
                end else if (i_step) begin
                    w_next = S_STEP_EXEC;
                end
            end
            S_STEP_EXEC: begin
                w_cpu_enable = 1'b1;
                w_next       = S_STEP_WAIT;
            end
            S_DUMP_ADDR: begin
                w_dump_active = 1'b1;
                w_rd_enable   = 1'b1;
                w_next        = S_DUMP_DATA;
            end
            S_DUMP_DATA: begin
                w_dump_active = 1'b1;
                w_dump_valid  = 1'b1;
                if (io_dump.i_dump_ready) begin
                    w_next = w_last ? S_DONE : S_DUMP_ADDR;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_step_mode   <= 1'b0;
            r_cycle_count <= '0;
            r_dump_addr   <= '0;
            r_dump_data   <= '0;
        end else begin
            r_state <= w_next;
            if (w_start_accept) begin
                r_step_mode   <= i_step_mode;
                r_cycle_count <= '0;
            end else if (w_cpu_enable && (r_cycle_count != '1)) begin
                r_cycle_count <= r_cycle_count + NB_CYCLES'(1);
            end
            if (w_dump_enter) begin
                r_dump_addr <= '0;
            end else if (w_handshake && !w_last) begin
                r_dump_addr <= r_dump_addr + NB_ADDR'(1);
            end
            if (r_state == S_DUMP_ADDR) begin
                r_dump_data <= io_dump.i_ram_data;
            end
        end
    end

`ifdef RUN_CTRL_WATCHDOG_EN
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_timeout <= 1'b0;
        end else if (w_start_accept) begin
            r_timeout <= 1'b0;
        end else if (w_wd_fire) begin
            r_timeout <= 1'b1;
        end
    end
    assign o_timeout = r_timeout;
`else
    assign o_timeout = 1'b0;
`endif

    assign o_cpu_enable            = w_cpu_enable;
    assign o_cpu_clear             = w_cpu_clear;
    assign o_cycle_count           = r_cycle_count;
    assign o_busy                  = (r_state != S_IDLE) && (r_state != S_DONE);
    assign o_done                  = (r_state == S_DONE);
    assign io_dump.o_dump_active   = w_dump_active;
    assign io_dump.o_ram_addr      = r_dump_addr;
    assign io_dump.o_ram_rd_enable = w_rd_enable;
    assign io_dump.o_dump_data     = r_dump_data;
    assign io_dump.o_dump_valid    = w_dump_valid;
endmodule

// File: tb/tb_cpu_run_controller.sv
// Bench for cpu_run_controller: a toy CPU (PC over a random program) and a RAM
// image drive the DUT; expectations come from program/RAM contents directly.
module tb_cpu_run_controller;
    localparam int NB_I   = 16;
    localparam int NB_A   = 11;
    localparam int NB_OP  = 5;
    localparam int DEPTH  = 16;
    localparam int NB_CYC = 7;
    localparam int WD     = 20;
    localparam int CYC_MAX = (1 << NB_CYC) - 1;
    localparam logic [NB_OP-1:0] HALT = '0;

    logic              i_clock = 1'b0;
    logic              i_reset = 1'b1;
    logic              i_start = 1'b0;
    logic              i_step_mode = 1'b0;
    logic              i_step = 1'b0;
    logic [NB_OP-1:0]  i_opcode;
    logic              o_cpu_enable, o_cpu_clear, o_busy, o_done, o_timeout;
    logic [NB_CYC-1:0] o_cycle_count;

    cpu_run_controller_if #(.NB_INSTRUCTION(NB_I), .NB_ADDR(NB_A)) dump_bus ();

    cpu_run_controller #(
        .NB_INSTRUCTION(NB_I), .NB_ADDR(NB_A), .NB_OPCODE(NB_OP), .HALT_OPCODE(0),
        .DUMP_DEPTH(DEPTH), .NB_CYCLES(NB_CYC), .WATCHDOG_LIMIT(WD)
    ) dut (
        .i_clock(i_clock), .i_reset(i_reset), .i_start(i_start), .i_step_mode(i_step_mode),
        .i_step(i_step), .i_opcode(i_opcode), .o_cpu_enable(o_cpu_enable),
        .o_cpu_clear(o_cpu_clear), .o_cycle_count(o_cycle_count), .o_busy(o_busy),
        .o_done(o_done), .o_timeout(o_timeout), .io_dump(dump_bus)
    );

    always #5 i_clock = ~i_clock;

    // Toy CPU and RAM image
    logic [NB_OP-1:0] prog [0:255];
    logic [NB_I-1:0]  mem  [0:DEPTH-1];
    logic [7:0]       pc = 8'd0;

    always @(posedge i_clock) begin
        if (i_reset || o_cpu_clear) pc <= 8'd0;
        else if (o_cpu_enable)      pc <= pc + 8'd1;
    end
    assign i_opcode = prog[pc];
    // Data outside a read strobe is deliberately wrong so mistimed captures show up
    assign dump_bus.i_ram_data = dump_bus.o_ram_rd_enable ? mem[dump_bus.o_ram_addr[3:0]]
                                                          : ~mem[dump_bus.o_ram_addr[3:0]];

    int n_vec = 0;
    int n_err = 0;
    int n_clear, n_enable, n_stall, n_stall_bad;
    logic [NB_I-1:0] words_q [$];
    int              addr_q  [$];
    logic            prev_stall = 1'b0;
    logic [NB_I-1:0] prev_data;
    logic [NB_A-1:0] prev_addr;

    always @(negedge i_clock) begin
        if (o_cpu_clear)  n_clear++;
        if (o_cpu_enable) n_enable++;
        if (dump_bus.o_ram_rd_enable) addr_q.push_back(int'(dump_bus.o_ram_addr));
        if (dump_bus.o_dump_valid && dump_bus.i_dump_ready) words_q.push_back(dump_bus.o_dump_data);
        if (prev_stall) begin
            n_stall++;
            if (!dump_bus.o_dump_valid || dump_bus.o_dump_data !== prev_data ||
                dump_bus.o_ram_addr !== prev_addr) n_stall_bad++;
        end
        prev_stall = dump_bus.o_dump_valid && !dump_bus.i_dump_ready;
        prev_data  = dump_bus.o_dump_data;
        prev_addr  = dump_bus.o_ram_addr;
    end

    function automatic int dump_errors();
        int e = 0;
        if (words_q.size() != DEPTH) e++;
        if (addr_q.size() != DEPTH) e++;
        for (int i = 0; i < words_q.size() && i < DEPTH; i++) if (words_q[i] !== mem[i]) e++;
        for (int i = 0; i < addr_q.size() && i < DEPTH; i++) if (addr_q[i] != i) e++;
        return e;
    endfunction

    function automatic int exp_count(input int n);
        return (n > CYC_MAX) ? CYC_MAX : n;
    endfunction

    task automatic tick();
        @(posedge i_clock);
        #1;
    endtask

    task automatic load_prog(input int halt_at);
        for (int i = 0; i < 256; i++) prog[i] = NB_OP'($urandom_range(1, (1 << NB_OP) - 1));
        if (halt_at >= 0 && halt_at < 256) prog[halt_at] = HALT;
        for (int i = 0; i < DEPTH; i++) mem[i] = NB_I'($urandom);
    endtask

    task automatic clear_monitor();
        n_clear = 0; n_enable = 0; n_stall = 0; n_stall_bad = 0;
        words_q.delete(); addr_q.delete();
        prev_stall = 1'b0;
    endtask

    task automatic do_reset();
        i_reset = 1'b1; i_start = 1'b0; i_step = 1'b0; dump_bus.i_dump_ready = 1'b0;
        tick(); tick();
        i_reset = 1'b0;
    endtask

    task automatic start_job(input bit mode);
        clear_monitor();
        i_step_mode = mode;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        i_step_mode = 1'($urandom);
    endtask

    task automatic wait_done(input int pct, input int bp_word, input int budget, output bit ok);
        int bp_left = 4;
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (o_done) begin
                ok = 1'b1;
                break;
            end
            i_step = 1'($urandom);
            if (bp_word >= 0 && words_q.size() == bp_word && bp_left > 0 && dump_bus.o_dump_valid) begin
                dump_bus.i_dump_ready = 1'b0;
                bp_left--;
            end else begin
                dump_bus.i_dump_ready = ($urandom_range(99) < pct);
            end
            tick();
        end
        i_step = 1'b0;
        dump_bus.i_dump_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if ({o_cpu_enable, o_cpu_clear, dump_bus.o_dump_active, dump_bus.o_ram_rd_enable,
             dump_bus.o_dump_valid, o_busy, o_done, o_timeout} !== 8'h00) begin
            n_err++;
            $display("FAIL reset_flags: got %b want 00000000", {o_cpu_enable, o_cpu_clear,
                     dump_bus.o_dump_active, dump_bus.o_ram_rd_enable, dump_bus.o_dump_valid,
                     o_busy, o_done, o_timeout});
        end
        n_vec++;
        if (o_cycle_count !== '0 || dump_bus.o_ram_addr !== '0 || dump_bus.o_dump_data !== '0) begin
            n_err++;
            $display("FAIL reset_values: got cnt=%0d addr=%0d data=%h want 0", o_cycle_count,
                     dump_bus.o_ram_addr, dump_bus.o_dump_data);
        end
    endtask

    task automatic test_free_run();
        int halts [4];
        bit ok;
        logic [NB_CYC-1:0] held;
        halts[0] = 5; halts[1] = 0;
        halts[2] = $urandom_range(1, 18); halts[3] = $urandom_range(1, 18);
        for (int k = 0; k < 4; k++) begin
            load_prog(halts[k]);
            start_job(1'b0);
            wait_done(70, -1, 600, ok);
            n_vec++;
            if (ok !== 1'b1) begin n_err++; $display("FAIL free_done: got timeout want done (halt %0d)", halts[k]); end
            n_vec++;
            if (n_clear != 1) begin n_err++; $display("FAIL free_clear: got %0d pulses want 1", n_clear); end
            n_vec++;
            if (int'(o_cycle_count) != exp_count(halts[k]) || n_enable != halts[k]) begin
                n_err++;
                $display("FAIL free_count: got cnt=%0d en=%0d want %0d", o_cycle_count, n_enable, halts[k]);
            end
            n_vec++;
            if (dump_errors() != 0) begin
                n_err++;
                $display("FAIL free_dump: got %0d bad entries (%0d words, %0d addrs) want 0",
                         dump_errors(), words_q.size(), addr_q.size());
            end
            held = o_cycle_count;
            tick(); tick(); tick();
            n_vec++;
            if ({o_done, o_busy, o_timeout} !== 3'b100 || o_cycle_count !== held) begin
                n_err++;
                $display("FAIL free_hold: got done/busy/to=%b cnt=%0d want 100 cnt=%0d",
                         {o_done, o_busy, o_timeout}, o_cycle_count, held);
            end
        end
    endtask

    task automatic test_step();
        bit ok;
        int n;
        for (int k = 0; k < 3; k++) begin
            n = (k == 0) ? 3 : $urandom_range(1, 6);
            load_prog(n);
            start_job(1'b1);
            tick();
            for (int s = 0; s < n; s++) begin
                i_step = 1'b1;
                tick();
                i_step = 1'b0;
                repeat ($urandom_range(1, 3)) tick();
            end
            wait_done(80, -1, 600, ok);
            n_vec++;
            if (ok !== 1'b1 || n_enable != n || int'(o_cycle_count) != n) begin
                n_err++;
                $display("FAIL step_pulses: got done=%0d en=%0d cnt=%0d want 1/%0d/%0d", ok,
                         n_enable, o_cycle_count, n, n);
            end
            n_vec++;
            if (dump_errors() != 0) begin n_err++; $display("FAIL step_dump: got %0d bad entries want 0", dump_errors()); end
        end
        // step held high for six cycles: one step per two cycles
        load_prog(3);
        start_job(1'b1);
        tick();
        i_step = 1'b1;
        repeat (6) tick();
        i_step = 1'b0;
        n_vec++;
        if (n_enable != 3 || o_cycle_count !== NB_CYC'(3)) begin
            n_err++;
            $display("FAIL step_held: got en=%0d cnt=%0d want 3/3", n_enable, o_cycle_count);
        end
        wait_done(80, -1, 600, ok);
        n_vec++;
        if (ok !== 1'b1 || dump_errors() != 0) begin
            n_err++;
            $display("FAIL step_held_dump: got done=%0d bad=%0d want 1/0", ok, dump_errors());
        end
    endtask

    task automatic test_priority();
        bit ok;
        load_prog(0);
        start_job(1'b1);
        i_step = 1'b1;
        repeat (3) tick();
        i_step = 1'b0;
        wait_done(80, -1, 600, ok);
        n_vec++;
        if (ok !== 1'b1 || n_enable != 0 || o_cycle_count !== '0 || dump_errors() != 0) begin
            n_err++;
            $display("FAIL halt_vs_step: got done=%0d en=%0d cnt=%0d bad=%0d want 1/0/0/0", ok,
                     n_enable, o_cycle_count, dump_errors());
        end
        load_prog(15);
        start_job(1'b0);
        repeat (5) tick();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        wait_done(80, -1, 600, ok);
        n_vec++;
        if (ok !== 1'b1 || n_clear != 1 || o_cycle_count !== NB_CYC'(15)) begin
            n_err++;
            $display("FAIL start_in_run: got done=%0d clears=%0d cnt=%0d want 1/1/15", ok, n_clear,
                     o_cycle_count);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        load_prog(2);
        start_job(1'b0);
        wait_done(100, 2, 600, ok);
        n_vec++;
        if (ok !== 1'b1 || dump_errors() != 0) begin
            n_err++;
            $display("FAIL bp_dump: got done=%0d bad=%0d words=%0d want 1/0/%0d", ok, dump_errors(),
                     words_q.size(), DEPTH);
        end
        n_vec++;
        if (n_stall != 4 || n_stall_bad != 0) begin
            n_err++;
            $display("FAIL bp_stall: got stalls=%0d unstable=%0d want 4/0", n_stall, n_stall_bad);
        end
    endtask

    task automatic test_reset_mid_dump();
        bit ok;
        bit found = 1'b0;
        load_prog(4);
        start_job(1'b0);
        dump_bus.i_dump_ready = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(negedge i_clock);
            if (dump_bus.o_dump_valid && dump_bus.o_ram_addr == NB_A'(7)) begin
                found = 1'b1;
                break;
            end
        end
        n_vec++;
        if (found !== 1'b1) begin n_err++; $display("FAIL rst_reach_word7: got not reached want reached"); end
        #1 i_reset = 1'b1;
        tick();
        n_vec++;
        if ({o_cpu_enable, o_cpu_clear, dump_bus.o_dump_active, dump_bus.o_ram_rd_enable,
             dump_bus.o_dump_valid, o_busy, o_done, o_timeout} !== 8'h00 ||
            o_cycle_count !== '0 || dump_bus.o_ram_addr !== '0 || dump_bus.o_dump_data !== '0) begin
            n_err++;
            $display("FAIL rst_mid_dump: got flags=%b cnt=%0d addr=%0d data=%h want all 0",
                     {o_cpu_enable, o_cpu_clear, dump_bus.o_dump_active, dump_bus.o_ram_rd_enable,
                      dump_bus.o_dump_valid, o_busy, o_done, o_timeout}, o_cycle_count,
                     dump_bus.o_ram_addr, dump_bus.o_dump_data);
        end
        i_reset = 1'b0;
        dump_bus.i_dump_ready = 1'b0;
        tick();
        load_prog(7);
        start_job(1'b0);
        wait_done(60, -1, 600, ok);
        n_vec++;
        if (ok !== 1'b1 || dump_errors() != 0 || o_cycle_count !== NB_CYC'(7)) begin
            n_err++;
            $display("FAIL rst_restart: got done=%0d bad=%0d cnt=%0d want 1/0/7", ok, dump_errors(),
                     o_cycle_count);
        end
    endtask

    task automatic test_watchdog();
        bit ok;
`ifdef RUN_CTRL_WATCHDOG_EN
        load_prog(-1);
        start_job(1'b0);
        wait_done(80, -1, 600, ok);
        n_vec++;
        if (ok !== 1'b1 || o_timeout !== 1'b1 || o_cycle_count !== NB_CYC'(WD) || n_enable != WD) begin
            n_err++;
            $display("FAIL wd_fire: got done=%0d to=%0d cnt=%0d en=%0d want 1/1/%0d/%0d", ok,
                     o_timeout, o_cycle_count, n_enable, WD, WD);
        end
        n_vec++;
        if (dump_errors() != 0) begin n_err++; $display("FAIL wd_dump: got %0d bad want 0", dump_errors()); end
        load_prog(5);
        start_job(1'b0);
        n_vec++;
        if (o_timeout !== 1'b0) begin n_err++; $display("FAIL wd_clear: got to=%0d want 0", o_timeout); end
        wait_done(80, -1, 600, ok);
`else
        load_prog(-1);
        start_job(1'b0);
        tick();
        repeat (100) tick();
        n_vec++;
        if (o_cpu_enable !== 1'b1 || o_busy !== 1'b1 || o_timeout !== 1'b0 ||
            int'(o_cycle_count) != exp_count(100)) begin
            n_err++;
            $display("FAIL nowd_run100: got en=%0d busy=%0d to=%0d cnt=%0d want 1/1/0/%0d",
                     o_cpu_enable, o_busy, o_timeout, o_cycle_count, exp_count(100));
        end
        repeat (60) tick();
        n_vec++;
        if (o_cpu_enable !== 1'b1 || int'(o_cycle_count) != exp_count(160)) begin
            n_err++;
            $display("FAIL nowd_saturate: got en=%0d cnt=%0d want 1/%0d", o_cpu_enable,
                     o_cycle_count, exp_count(160));
        end
        do_reset();
        ok = 1'b1;
`endif
        n_vec++;
        if (ok !== 1'b1) begin n_err++; $display("FAIL wd_finish: got not done want done"); end
    endtask

    initial begin
        dump_bus.i_dump_ready = 1'b0;
        load_prog(-1);
        test_reset();
        test_free_run();
        test_step();
        test_priority();
        test_backpressure();
        test_reset_mid_dump();
        test_watchdog();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_time_limit: got no finish want finish");
        $fatal(1, "simulation time limit");
    end
endmodule

// File: doc/cpu_run_controller.md
CPU_RUN_CONTROLLER -- requirements
Module: cpu_run_controller

Interface
REQ-001 The block SHALL have parameter NB_INSTRUCTION, default 16, meaning the data word width.
REQ-002 The block SHALL have parameter NB_ADDR, default 11, meaning the RAM address width.
REQ-003 The block SHALL have parameter NB_OPCODE, default 5, meaning the opcode field width.
REQ-004 The block SHALL have parameter HALT_OPCODE, default 0, meaning the opcode that stops execution.
REQ-005 The block SHALL have parameter DUMP_DEPTH, default 16, meaning the number of RAM words dumped, counted from address 0.
REQ-006 The block SHALL have parameter NB_CYCLES, default 16, meaning the width of the cycle counter.
REQ-007 The block SHALL have parameter WATCHDOG_LIMIT, default 1000, meaning the RUN-cycle budget.
REQ-008 The block SHALL have port i_clock, input, 1 bit: the single clock; all logic uses its rising edge.
REQ-009 The block SHALL have port i_reset, input, 1 bit: synchronous, active-high reset.
REQ-010 The block SHALL have port i_start, input, 1 bit: start pulse.
REQ-011 The block SHALL have port i_step_mode, input, 1 bit: selects step mode when 1 and free run when 0; sampled only when i_start is accepted.
REQ-012 The block SHALL have port i_step, input, 1 bit: single-step pulse.
REQ-013 The block SHALL have port i_opcode, input, NB_OPCODE bits: opcode of the instruction currently fetched by the CPU.
REQ-014 The block SHALL have port i_ram_data, input, NB_INSTRUCTION bits: RAM read data, valid one cycle after the address is presented.
REQ-015 The block SHALL have port i_dump_ready, input, 1 bit: consumer accepts the dump word.
REQ-016 The block SHALL have port o_cpu_enable, output, 1 bit: CPU advance enable.
REQ-017 The block SHALL have port o_cpu_clear, output, 1 bit: one-cycle synchronous clear pulse to the CPU.
REQ-018 The block SHALL have port o_dump_active, output, 1 bit: the block owns the RAM port; the top-level address mux selects the block's address.
REQ-019 The block SHALL have port o_ram_addr, output, NB_ADDR bits: dump read address.
REQ-020 The block SHALL have port o_ram_rd_enable, output, 1 bit: dump read strobe.
REQ-021 The block SHALL have port o_dump_data, output, NB_INSTRUCTION bits: dump word.
REQ-022 The block SHALL have port o_dump_valid, output, 1 bit: o_dump_data is valid.
REQ-023 The block SHALL have port o_cycle_count, output, NB_CYCLES bits: number of executed CPU cycles.
REQ-024 The block SHALL have port o_busy, output, 1 bit: state is neither IDLE nor DONE.
REQ-025 The block SHALL have port o_done, output, 1 bit: the dump has completed.
REQ-026 The block SHALL have port o_timeout, output, 1 bit: the watchdog has expired.

Function
REQ-027 The FSM SHALL have the states IDLE, CLEAR, RUN, STEP_WAIT, STEP_EXEC, DUMP_ADDR, DUMP_DATA and DONE.
REQ-028 In IDLE or DONE, i_start SHALL cause a transition to CLEAR, which clears o_cycle_count, o_done and o_timeout; i_start SHALL be ignored in all other states.
REQ-029 CLEAR SHALL last exactly one cycle with o_cpu_clear=1, then go to STEP_WAIT if the latched step mode is 1, else to RUN.
REQ-030 In RUN, o_cpu_enable SHALL equal (i_opcode != HALT_OPCODE), combinationally; o_cycle_count SHALL increment on each enabled cycle and saturate at all-ones.
REQ-031 In RUN, i_opcode == HALT_OPCODE SHALL cause a transition to DUMP_ADDR on the next edge; the HALT instruction itself SHALL not be counted.
REQ-032 In STEP_WAIT, o_cpu_enable SHALL be 0; i_opcode == HALT_OPCODE SHALL cause DUMP_ADDR (taking priority over i_step); otherwise i_step SHALL cause STEP_EXEC.
REQ-033 STEP_EXEC SHALL assert o_cpu_enable for exactly one cycle, increment o_cycle_count, then return to STEP_WAIT; i_step held high SHALL yield one step per two cycles.
REQ-034 i_step SHALL be ignored outside STEP_WAIT.
REQ-035 The dump address counter SHALL start at 0 on entering DUMP.
REQ-036 DUMP_ADDR SHALL drive o_ram_addr equal to the counter with o_ram_rd_enable=1 for one cycle, then go to DUMP_DATA.
REQ-037 DUMP_DATA SHALL register i_ram_data into o_dump_data on entry and hold o_dump_valid=1 with o_dump_data stable until i_dump_ready=1.
REQ-038 On the handshake (o_dump_valid and i_dump_ready both 1), the block SHALL go to DUMP_ADDR with counter+1, or to DONE if the counter equals DUMP_DEPTH-1.
REQ-039 o_dump_active SHALL be 1 in DUMP_ADDR and DUMP_DATA only, and o_cpu_enable SHALL be 0 there.
REQ-040 DONE SHALL hold o_done=1 and retain o_cycle_count and o_timeout until the next accepted i_start.

Reset
REQ-041 While i_reset=1, at any state and mid-operation, the block SHALL enter IDLE on the next edge and drive o_cpu_enable, o_cpu_clear, o_dump_active, o_ram_rd_enable, o_dump_valid, o_busy, o_done and o_timeout to 0, and o_ram_addr, o_dump_data and o_cycle_count to 0.
REQ-042 i_reset SHALL take priority over every other input.

Configuration
REQ-043 With macro RUN_CTRL_WATCHDOG_EN defined, reaching o_cycle_count == WATCHDOG_LIMIT in RUN SHALL force DUMP_ADDR and set o_timeout=1 until the next accepted i_start or reset; step mode SHALL be exempt from the watchdog.
REQ-044 Without RUN_CTRL_WATCHDOG_EN, o_timeout SHALL be constant 0 and RUN SHALL end only on HALT_OPCODE or reset.

Verification
REQ-045 Free run: i_start with mode 0 and HALT at the 6th fetch -> one-cycle o_cpu_clear, o_cycle_count=5, 16 dump words at addresses 0..15, then o_done=1.
REQ-046 Step mode: i_start with mode 1 and three i_step pulses -> exactly three single-cycle o_cpu_enable pulses and o_cycle_count=3; a step arriving during STEP_EXEC is ignored.
REQ-047 Backpressure: hold i_dump_ready=0 for 4 cycles on word 2 -> o_dump_valid stays 1 with o_dump_data constant, o_ram_addr does not advance, and no word is lost or duplicated.
REQ-048 i_reset asserted during DUMP_DATA word 7 -> next cycle IDLE with all outputs at their reset values; a following i_start restarts cleanly from address 0.
REQ-049 With RUN_CTRL_WATCHDOG_EN and WATCHDOG_LIMIT=20 on a program that never halts -> o_timeout=1 and the dump starts after cycle 20; without the macro, the CPU is still enabled at cycle 100.
REQ-050 i_start asserted during RUN, and HALT coinciding with i_step in STEP_WAIT -> the start is ignored, and the HALT wins, entering DUMP_ADDR without a step.
